// File: rtl/snpu_rnd_pkg.sv
// Shared types and constants for the latch-cell entropy harvester.
//   state_e       harvester sequencer states
//   BYTE_W        width of a delivered random byte
//   *_DEF         default parameter values of snpu_rnd_harvester
package snpu_rnd_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned N_CELLS_DEF       = 16;
    localparam int unsigned EXCITE_CYCLES_DEF = 4;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned FAIL_LIMIT_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        SAMPLE,
        PROCESS
    } state_e;

endpackage

// File: rtl/snpu_vn_debias.sv
// Von Neumann debiaser for one bit pair (combinational).
//   pair         {a, b}: a = upper cell, b = lower cell
//   bit_valid_c  1 when a != b (pair yields a bit)
//   bit_value_c  the yielded bit (a)
module snpu_vn_debias (
    input  logic [1:0] pair,
    output logic       bit_valid_c,
    output logic       bit_value_c
);

    assign bit_valid_c = pair[1] ^ pair[0];
    assign bit_value_c = pair[1];

endmodule

// File: rtl/snpu_rnd_harvester.sv
// Sequencer for an array of cross-coupled NAND-latch entropy cells.
// Excites the cells, samples them after release, debiases bit pairs and packs
// the surviving bits into bytes on a valid/ready port. Flags poor entropy.
//   clk, rst_n    clock, asynchronous active-low reset
//   enable_i      run harvesting rounds
//   gen_o         shared G line: 0 = excite, 1 = release/freeze
//   raw_i         latch outputs, asynchronous to clk
//   out_data      harvested byte, out_valid/out_ready handshake
//   health_clr    clears health_fail and the zero-yield round counter
//   health_fail   sticky: FAIL_LIMIT consecutive rounds yielded no bits
module snpu_rnd_harvester
    import snpu_rnd_pkg::*;
#(
    parameter int unsigned N_CELLS       = N_CELLS_DEF,
    parameter int unsigned EXCITE_CYCLES = EXCITE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned FAIL_LIMIT    = FAIL_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    output logic               gen_o,
    input  logic [N_CELLS-1:0] raw_i,
    output logic [BYTE_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               health_clr,
    output logic               health_fail
);

    localparam int unsigned NPAIRS  = N_CELLS / 2;
    localparam int unsigned PW      = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int unsigned CNT_MAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FW      = $clog2(FAIL_LIMIT + 1);
    localparam int unsigned AW      = $clog2(BYTE_W);

    state_e              state;
    state_e              state_nxt;
    logic [N_CELLS-1:0]  sync1;
    logic [N_CELLS-1:0]  sync2;
    logic [N_CELLS-1:0]  raw_q;
    logic [CW-1:0]       cyc_cnt;
    logic [PW-1:0]       pair_idx;
    logic                round_hit;
    logic [BYTE_W-2:0]   acc;
    logic [AW-1:0]       acc_cnt;
    logic [FW-1:0]       fail_cnt;

    logic                bit_valid_c;
    logic                bit_value_c;
    logic                emit_c;
    logic                byte_done_c;
    logic                stall_c;
    logic                advance_c;
    logic                round_end_c;
    logic                store_c;
    logic                load_c;
    logic                zero_round_c;
    logic                health_set_c;

    snpu_vn_debias u_debias (
        .pair        (raw_q[{pair_idx, 1'b0} +: 2]),
        .bit_valid_c (bit_valid_c),
        .bit_value_c (bit_value_c)
    );

    // Next-state and datapath control strobes.
    always_comb begin
        state_nxt    = state;
        emit_c       = (state == PROCESS) && bit_valid_c && !health_fail;
        byte_done_c  = emit_c && (acc_cnt == AW'(BYTE_W - 1));
        // A completing byte waits only if the output slot is full and not draining.
        stall_c      = byte_done_c && out_valid && !out_ready;
        advance_c    = (state == PROCESS) && !stall_c;
        round_end_c  = advance_c && (pair_idx == PW'(NPAIRS - 1));
        store_c      = emit_c && !byte_done_c;
        load_c       = byte_done_c && !stall_c;
        zero_round_c = round_end_c && !round_hit && !bit_valid_c;
        health_set_c = zero_round_c && (fail_cnt >= FW'(FAIL_LIMIT - 1));

        unique case (state)
            IDLE:    if (enable_i) state_nxt = EXCITE;
            EXCITE:  if (cyc_cnt == CW'(EXCITE_CYCLES - 1)) state_nxt = SETTLE;
            SETTLE:  if (cyc_cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = PROCESS;
            PROCESS: if (round_end_c) state_nxt = enable_i ? EXCITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; gen_o tracks the state so it is low exactly during EXCITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gen_o <= 1'b1;
        end else begin
            state <= state_nxt;
            gen_o <= (state_nxt != EXCITE);
        end
    end

    // Two-flop synchroniser on the asynchronous cell outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_i;
            sync2 <= sync1;
        end
    end

    // Phase counter, sample capture and pair walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            pair_idx  <= '0;
            round_hit <= 1'b0;
            raw_q     <= '0;
        end else begin
            if ((state == EXCITE || state == SETTLE) && state_nxt == state)
                cyc_cnt <= cyc_cnt + CW'(1);
            else
                cyc_cnt <= '0;

            if (state == SAMPLE) begin
                raw_q     <= sync2;
                pair_idx  <= '0;
                round_hit <= 1'b0;
            end else if (advance_c) begin
                pair_idx  <= pair_idx + PW'(1);
                round_hit <= round_hit | bit_valid_c;
            end
        end
    end

    // Bit packer and output slot; a load may coincide with a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (health_set_c && !health_clr) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (load_c) begin
                acc_cnt <= '0;
            end else if (store_c) begin
                acc[acc_cnt] <= bit_value_c;
                acc_cnt      <= acc_cnt + AW'(1);
            end

            if (load_c) begin
                out_data  <= {bit_value_c, acc};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Consecutive zero-yield round counter and sticky health flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt    <= '0;
            health_fail <= 1'b0;
        end else if (health_clr) begin
            fail_cnt    <= '0;
            health_fail <= 1'b0;
        end else begin
            if (zero_round_c) begin
                if (fail_cnt != FW'(FAIL_LIMIT)) fail_cnt <= fail_cnt + FW'(1);
            end else if (round_end_c) begin
                fail_cnt <= '0;
            end
            if (health_set_c) health_fail <= 1'b1;
        end
    end

endmodule
